// File: rtl/vga_pkg.sv
// Shared video constants and the display-fetch state encoding used by the
// VRAM arbiter and its bench.
package vga_pkg;
    localparam int DEF_H_RES      = 640;
    localparam int DEF_V_RES      = 480;
    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_LOW_WM     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;
endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO holding prefetched palette indices; the head is
// visible on head_data without a pop, and reads as zero while empty.
module pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (level_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && ((level_q != LVL_W'(DEPTH)) || pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display prefetch reads compete with a
// writer port; display wins only when its buffer is running low.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LOW_WM     = DEF_LOW_WM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pix_rd,
    output logic [7:0]                    pix_data,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ack,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [7:0]                    mem_wdata,
    input  logic [7:0]                    mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = LVL_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  LOW_OCC   = OCC_W'(LOW_WM);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              inflight_q;
    logic              underflow_q;
    logic [LVL_W-1:0]  level;
    logic [OCC_W-1:0]  occ;
    logic              fifo_empty;
    logic              fetch_ok;
    logic              rd_issue;
    logic              wr_grant;
    logic              push;

    // Occupancy counts the read whose data lands next cycle, so room is never overcommitted.
    assign occ      = OCC_W'(level) + OCC_W'(inflight_q);
    assign fetch_ok = (state_q == ST_FETCH) && !frame_start && !rst;

    always_comb begin
        rd_issue = 1'b0;
        wr_grant = 1'b0;
        if (fetch_ok && (occ < LOW_OCC))        rd_issue = 1'b1;
        else if (wr_req && !rst)                wr_grant = 1'b1;
        else if (fetch_ok && (occ < DEPTH_OCC)) rd_issue = 1'b1;
    end

    assign mem_we    = wr_grant;
    assign wr_ack    = wr_grant;
    assign mem_wdata = wr_grant ? wr_data : 8'h00;
    assign mem_addr  = wr_grant ? wr_addr : (rd_issue ? fetch_addr_q : '0);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        if (frame_start) begin
            state_d      = ST_FETCH;
            fetch_addr_d = '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (rd_issue) begin
                        fetch_addr_d = fetch_addr_q + 1'b1;
                        if (fetch_addr_q == LAST_ADDR) state_d = ST_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= rd_issue;
            underflow_q  <= underflow_q | (pix_rd & fifo_empty);
        end
    end

    // Data returning across a frame restart belongs to the old frame and is dropped.
    assign push = inflight_q && !frame_start;

    pixel_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pix_rd),
        .head_data (pix_data),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign fifo_level = level;
    assign underflow  = underflow_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter: a queue-based model of the pixel buffer
// and arbitration rules predicts every bus cycle and display output.
module tb_vram_arbiter;
    import vga_pkg::*;

    localparam int H     = 16;
    localparam int V     = 12;
    localparam int NPIX  = H * V;
    localparam int AW    = 19;
    localparam int DEPTH = 16;
    localparam int LWM   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          pix_rd;
    logic [7:0]    pix_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [4:0]    fifo_level;
    logic          underflow;

    vram_arbiter #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, read data one cycle after the address.
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] gold(int a);
        return 8'((a * 37) ^ (a >> 3) ^ 8'h5C);
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: buffer contents, pending read address, fetch progress.
    logic [7:0] mq[$];
    int  m_pend  = -1;
    bit  m_fetch = 0;
    int  m_addr  = 0;
    bit  m_uf    = 0;
    bit  last_rd = 0;

    logic          obs_ack, obs_we;
    logic [AW-1:0] obs_addr;
    logic [7:0]    obs_wdata, obs_pix;

    task automatic new_wr();
        wr_req  = 1'b1;
        wr_addr = AW'(NPIX + $urandom_range(0, 4000));
        wr_data = 8'($urandom);
    endtask

    task automatic step();
        int occ;
        bit can, do_rd, do_wr;
        #1;
        occ   = mq.size() + ((m_pend >= 0) ? 1 : 0);
        can   = m_fetch && !frame_start && !rst;
        do_rd = 0;
        do_wr = 0;
        if (!rst) begin
            if (can && occ < LWM)        do_rd = 1;
            else if (wr_req)             do_wr = 1;
            else if (can && occ < DEPTH) do_rd = 1;
        end
        obs_ack = wr_ack; obs_we = mem_we; obs_addr = mem_addr;
        obs_wdata = mem_wdata; obs_pix = pix_data;
        chk("mem_we", 32'(mem_we), 32'(do_wr));
        chk("wr_ack", 32'(wr_ack), 32'(do_wr));
        if (do_wr)      chk("wr_addr_bus", 32'(mem_addr), 32'(wr_addr));
        else if (do_rd) chk("rd_addr_bus", 32'(mem_addr), 32'(m_addr));
        else if (rst)   chk("rst_addr_bus", 32'(mem_addr), 0);
        if (do_wr)      chk("wdata_bus", 32'(mem_wdata), 32'(wr_data));
        else if (rst)   chk("rst_wdata_bus", 32'(mem_wdata), 0);
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("pix_data", 32'(pix_data), (mq.size() > 0) ? 32'(mq[0]) : 0);
        chk("underflow", 32'(underflow), 32'(m_uf));
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_pend = -1; m_fetch = 0; m_addr = 0; m_uf = 0;
        end else begin
            if (pix_rd && mq.size() == 0) m_uf = 1;
            if (frame_start) begin
                mq.delete(); m_pend = -1; m_addr = 0; m_fetch = 1;
            end else begin
                if (pix_rd && mq.size() > 0) void'(mq.pop_front());
                if (m_pend >= 0) mq.push_back(gold(m_pend));
                m_pend = do_rd ? m_addr : -1;
                if (do_rd) begin
                    m_addr++;
                    if (m_addr == NPIX) m_fetch = 0;
                end
            end
        end
        last_rd = pix_rd;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd, cyc;
        bit got;
        for (int i = 0; i < (1 << AW); i++) ram[i] = gold(i);
        rst = 1; frame_start = 1; pix_rd = 0; wr_req = 1; wr_addr = 'h55; wr_data = 8'h33;
        @(negedge clk);
        step();
        frame_start = 0; wr_req = 0;
        step();
        rst = 0;
        step();
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_pix", 32'(pix_data), 0);

        // Fill after frame start: reads 0..15 back to back then quiet bus.
        frame_start = 1; step(); frame_start = 0;
        repeat (24) step();
        chk("settle_level", 32'(fifo_level), 16);
        chk("settle_idle", 32'(mem_we), 0);

        // Writer against a full buffer.
        wr_req = 1; wr_addr = 'h100; wr_data = 8'hA5;
        step();
        chk("full_wr_ack", 32'(obs_ack), 1);
        chk("full_wr_we", 32'(obs_we), 1);
        chk("full_wr_addr", 32'(obs_addr), 'h100);
        chk("full_wr_data", 32'(obs_wdata), 'hA5);
        wr_req = 0; step();

        // Held writer across a restart: urgent reads until occupancy reaches LOW_WM.
        new_wr(); frame_start = 1; step(); frame_start = 0;
        if (obs_ack) new_wr();
        n_rd = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (obs_ack) begin got = 1; break; end
            if (!obs_we) n_rd++;
        end
        chk("urgent_ack_seen", 32'(got), 1);
        chk("urgent_reads_before_ack", 32'(n_rd), LWM);
        wr_req = 0;

        // Whole frame drained at half rate with random writer traffic.
        frame_start = 1; step(); frame_start = 0;
        repeat (10) step();
        cyc = 0;
        while ((m_fetch || mq.size() > 0) && cyc < 3000) begin
            pix_rd = !last_rd && (mq.size() > 0);
            if (!wr_req && $urandom_range(0, 3) == 0) new_wr();
            step();
            if (obs_ack) wr_req = 0;
            cyc++;
        end
        pix_rd = 0; wr_req = 0;
        chk("frame_in_time", 32'(cyc < 3000), 1);
        chk("frame_done_state", 32'(dut.state_q), 32'(ST_DONE));
        chk("frame_underflow", 32'(underflow), 0);
        step();
        chk("done_bus_idle", 32'(obs_we), 0);

        // Restart with ten entries buffered and a read outstanding.
        frame_start = 1; step(); frame_start = 0;
        cyc = 0;
        while (mq.size() != 10 && cyc < 50) begin step(); cyc++; end
        chk("fill_to_10", 32'(fifo_level), 10);
        frame_start = 1; step(); frame_start = 0;
        chk("fs_level_zero", 32'(fifo_level), 0);
        step();
        chk("fs_first_addr", 32'(obs_addr), 0);
        chk("fs_first_is_read", 32'(obs_we), 0);
        step();
        chk("fs_new_head", 32'(pix_data), 32'(gold(0)));

        // Pop on an empty buffer.
        frame_start = 1; step(); frame_start = 0;
        pix_rd = 1; step(); pix_rd = 0;
        chk("empty_pix_data", 32'(obs_pix), 0);
        chk("empty_pop_underflow", 32'(underflow), 1);
        repeat (5) step();
        chk("underflow_sticky", 32'(underflow), 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            frame_start = ($urandom_range(0, 99) == 0);
            pix_rd = !last_rd && ($urandom_range(0, 1) == 1);
            if (!wr_req && $urandom_range(0, 2) == 0) new_wr();
            step();
            if (obs_ack) wr_req = 0;
        end
        frame_start = 0; pix_rd = 0;

        rst = 1; new_wr(); step(); rst = 0; wr_req = 0;
        step();
        chk("final_rst_underflow", 32'(underflow), 0);
        chk("final_rst_level", 32'(fifo_level), 0);
        chk("final_rst_pix", 32'(pix_data), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter H_RES, 640, visible pixels per line.
REQ-002 SHALL have parameter V_RES, 480, visible lines per frame.
REQ-003 SHALL have parameter ADDR_W, 19, video RAM address width (covers H_RES*V_RES bytes).
REQ-004 SHALL have parameter FIFO_DEPTH, 16, pixel prefetch FIFO entries (power of two).
REQ-005 SHALL have parameter LOW_WM, 8, urgency threshold for display fetch.
REQ-006 SHALL have port clk  input  1  system clock; reset rst, synchronous, active-high; clock clk.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse in vertical blank, restarts frame fetch.
REQ-009 SHALL have port pix_rd  input  1  display pops one pixel; asserted at most every other cycle.
REQ-010 SHALL have port pix_data  output  8  FIFO head palette index (show-ahead), 8'h00 when empty.
REQ-011 SHALL have port wr_req  input  1  writer request; held with wr_addr/wr_data until wr_ack.
REQ-012 SHALL have port wr_addr  input  ADDR_W  writer byte address.
REQ-013 SHALL have port wr_data  input  8  writer pixel.
REQ-014 SHALL have port wr_ack  output  1  one-cycle pulse, write issued this cycle.
REQ-015 SHALL have ports mem_addr output ADDR_W, mem_we output 1, mem_wdata output 8, mem_rdata input 8: single-port RAM, read data valid exactly 1 cycle after read issue.
REQ-016 SHALL have ports fifo_level output 5 (entries held) and underflow output 1 (sticky pop-while-empty flag).

Function
REQ-017 SHALL implement states IDLE, FETCH, DONE; reset -> IDLE; frame_start -> FETCH from any state; FETCH -> DONE when read of address H_RES*V_RES-1 issued.
REQ-018 SHALL issue at most one memory operation per cycle.
REQ-019 SHALL issue display reads only in FETCH, only when fifo_level + reads in flight < FIFO_DEPTH.
REQ-020 SHALL treat display as urgent when fifo_level + in-flight < LOW_WM; urgent display read beats writer.
REQ-021 SHALL grant writer when wr_req and display not urgent (or state not FETCH); drive mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1 in the same cycle.
REQ-022 SHALL otherwise issue a non-urgent display read when room exists; else idle bus (mem_we=0).
REQ-023 SHALL start fetch at address 0 and increment by 1 per read; no wrap before frame_start.
REQ-024 SHALL push mem_rdata into FIFO the cycle after each display read.
REQ-025 SHALL, on frame_start, flush FIFO, reset fetch address to 0, discard in-flight read data, and not issue a display read in that cycle.
REQ-026 SHALL pop on pix_rd when non-empty; pix_rd while empty sets underflow, no pointer change.
REQ-027 SHALL handle push and pop in the same cycle with fifo_level unchanged.
REQ-028 SHALL never assert wr_ack without wr_req.

Reset
REQ-029 SHALL on rst clear state to IDLE, FIFO empty, fifo_level=0, fetch address 0, in-flight cleared, underflow=0, wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_data=8'h00.
REQ-030 SHALL let rst override frame_start and all requests; underflow cleared only by rst.

Structure
REQ-031 SHALL place H_RES, V_RES, ADDR_W, FIFO_DEPTH, LOW_WM defaults and the state enumeration in shared package vga_pkg.
REQ-032 SHALL instantiate one sub-module pixel_fifo (show-ahead, synchronous, level output).

Verification
REQ-033 Reset, frame_start, no pix_rd -> reads at addresses 0..15 on consecutive cycles, fifo_level settles at 16, bus idle.
REQ-034 Full FIFO, wr_req addr 0x00100 data 0xA5 -> wr_ack same cycle, mem_we=1, mem_addr=0x00100, mem_wdata=0xA5.
REQ-035 fifo_level=4 with wr_req held -> display read wins until level+in-flight=8, then wr_ack.
REQ-036 pix_rd every other cycle for a full frame -> pixels equal RAM 0..307199 in order, DONE reached, underflow=0.
REQ-037 frame_start with read in flight and level=10 -> next cycle level=0, stale data dropped, first new read address 0.
REQ-038 pix_rd on empty FIFO -> pix_data=8'h00, underflow=1, held until rst.
